if_vec_fetch: RTL and testbench

//  Parametrised instruction-fetch PC unit with a built-in vectored interrupt controller.

---
 rtl/if_vec_fetch.sv | 134 +++++++++++++
 tb/tb_if_vec_fetch.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/if_vec_fetch.sv
// -----------------------------------------------------------------------------
// if_vec_fetch
//   Instruction-fetch PC unit with a built-in vectored interrupt controller.
//   Holds the PC and drives it out as the instruction address. Each cycle one
//   next-PC is chosen from: hold (stall), return-from-interrupt, interrupt
//   vector, branch target, sequential increment, or hold (no instruction yet).
//   IRQ rising edges are latched as pending; the lowest enabled pending line is
//   taken, the return PC is saved in epc, and nesting is blocked until mret.
//
// Ports
//   clk        in   1          system clock, rising edge
//   rst_n      in   1          asynchronous active-low reset
//   irq        in   IRQ_NUM    interrupt request lines, rising-edge sensitive
//   irq_en     in   IRQ_NUM    per-line enable mask
//   jump_flag  in   1          branch/jump taken this cycle
//   branch_pc  in   CPU_WIDTH  branch target
//   mret       in   1          return-from-interrupt strobe
//   stall      in   1          freeze fetch (PC, state, epc hold)
//   inst_data  in   CPU_WIDTH  fetched instruction; 0 = not ready, PC holds
//   inst_addr  out  CPU_WIDTH  current PC
//   irq_ack    out  IRQ_NUM    one-hot 1-cycle pulse while PC is at the vector
//   in_isr     out  1          handler active
//   epc        out  CPU_WIDTH  saved return PC
// -----------------------------------------------------------------------------
module if_vec_fetch #(
   parameter int CPU_WIDTH  = 16,
   parameter int IRQ_NUM    = 8,
   parameter int VEC_BASE   = 0,
   parameter int VEC_STRIDE = 4,
   parameter int RESET_PC   = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [IRQ_NUM-1:0]   irq,
   input  logic [IRQ_NUM-1:0]   irq_en,
   input  logic                 jump_flag,
   input  logic [CPU_WIDTH-1:0] branch_pc,
   input  logic                 mret,
   input  logic                 stall,
   input  logic [CPU_WIDTH-1:0] inst_data,
   output logic [CPU_WIDTH-1:0] inst_addr,
   output logic [IRQ_NUM-1:0]   irq_ack,
   output logic                 in_isr,
   output logic [CPU_WIDTH-1:0] epc
);

   typedef enum logic {ST_RUN = 1'b0, ST_ISR = 1'b1} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CPU_WIDTH-1:0] r_pc;
   logic [CPU_WIDTH-1:0] r_epc;
   logic [IRQ_NUM-1:0]   r_pending;
   logic [IRQ_NUM-1:0]   r_irq_d;
   logic [IRQ_NUM-1:0]   r_ack;

   logic [IRQ_NUM-1:0]   w_edge;
   logic [IRQ_NUM-1:0]   w_masked;
   logic [4:0]           w_idx;
   logic                 w_take;
   logic [IRQ_NUM-1:0]   w_take_oh;
   logic [CPU_WIDTH-1:0] w_vec;
   logic [CPU_WIDTH-1:0] w_pc_inc;
   logic [CPU_WIDTH-1:0] w_pc_nxt;
   logic [CPU_WIDTH-1:0] w_epc_nxt;
   logic [IRQ_NUM-1:0]   w_pending_nxt;

   // Interrupt selection: lowest enabled pending line wins
   always_comb begin
      w_edge   = irq & ~r_irq_d;
      w_masked = r_pending & irq_en;
      w_idx    = '0;
      // Scan downward so the last hit is the lowest index
      for (int i = IRQ_NUM - 1; i >= 0; i--) begin
         if (w_masked[i]) w_idx = 5'(i);
      end
      w_take    = (r_state == ST_RUN) && (|w_masked) && !stall;
      w_take_oh = w_take ? (IRQ_NUM'(1) << w_idx) : '0;
      w_vec     = CPU_WIDTH'(VEC_BASE + int'(w_idx) * VEC_STRIDE);
      w_pc_inc  = r_pc + CPU_WIDTH'(1);
      // A fresh edge in the take cycle re-arms the line just cleared
      w_pending_nxt = (r_pending & ~w_take_oh) | w_edge;
   end

   // Next-PC / next-state selection in priority order
   always_comb begin
      w_pc_nxt    = r_pc;
      w_epc_nxt   = r_epc;
      w_state_nxt = r_state;
      if (stall) begin
         w_pc_nxt = r_pc;
      end else if (mret && (r_state == ST_ISR)) begin
         w_pc_nxt    = r_epc;
         w_state_nxt = ST_RUN;
      end else if (w_take) begin
         w_pc_nxt    = w_vec;
         // Keep a coincident branch as the return point so it is not lost
         w_epc_nxt   = jump_flag ? branch_pc : w_pc_inc;
         w_state_nxt = ST_ISR;
      end else if (jump_flag) begin
         w_pc_nxt = branch_pc;
      end else if (inst_data != '0) begin
         w_pc_nxt = w_pc_inc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_RUN;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc      <= CPU_WIDTH'(RESET_PC);
         r_epc     <= '0;
         r_pending <= '0;
         r_irq_d   <= '0;
         r_ack     <= '0;
      end else begin
         r_pc      <= w_pc_nxt;
         r_epc     <= w_epc_nxt;
         r_pending <= w_pending_nxt;
         r_irq_d   <= irq;
         // Ack lands in the same cycle the PC reaches the vector
         r_ack     <= w_take_oh;
      end
   end

   assign inst_addr = r_pc;
   assign irq_ack   = r_ack;
   assign in_isr    = (r_state == ST_ISR);
   assign epc       = r_epc;

endmodule

// File: tb/tb_if_vec_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_vec_fetch
//   Directed bench for if_vec_fetch with default parameters (16-bit PC, 8 IRQ
//   lines, vectors at 0 + 4*idx). Expected outputs are queued with each
//   stimulus step and compared one clock later (1 time unit after the edge).
// -----------------------------------------------------------------------------
module tb_if_vec_fetch;

   localparam int CW = 16;
   localparam int IN = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [IN-1:0] irq;
   logic [IN-1:0] irq_en;
   logic          jump_flag;
   logic [CW-1:0] branch_pc;
   logic          mret;
   logic          stall;
   logic [CW-1:0] inst_data;
   logic [CW-1:0] inst_addr;
   logic [IN-1:0] irq_ack;
   logic          in_isr;
   logic [CW-1:0] epc;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      int          sel;   // 0 pc, 1 ack, 2 in_isr, 3 epc
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];

   if_vec_fetch #(
      .CPU_WIDTH(CW), .IRQ_NUM(IN), .VEC_BASE(0), .VEC_STRIDE(4), .RESET_PC(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .irq(irq), .irq_en(irq_en),
      .jump_flag(jump_flag), .branch_pc(branch_pc), .mret(mret),
      .stall(stall), .inst_data(inst_data), .inst_addr(inst_addr),
      .irq_ack(irq_ack), .in_isr(in_isr), .epc(epc)
   );

   always #5 clk = ~clk;

   task automatic push(input string tag, input int sel, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = val;
      sb.push_back(e);
   endtask

   // Expect pc / in_isr / ack together (the common case)
   task automatic exp3(input string tag, input logic [31:0] pc,
                       input logic [31:0] isr, input logic [31:0] ack);
      push({tag, "_pc"}, 0, pc);
      push({tag, "_isr"}, 2, isr);
      push({tag, "_ack"}, 1, ack);
   endtask

   task automatic drain();
      exp_t        e;
      logic [31:0] obs;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.sel)
            0:       obs = 32'(inst_addr);
            1:       obs = 32'(irq_ack);
            2:       obs = 32'(in_isr);
            default: obs = 32'(epc);
         endcase
         checks++;
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drain();
   endtask

   initial begin
      rst_n     = 1'b0;
      irq       = '0;
      irq_en    = '0;
      jump_flag = 1'b0;
      branch_pc = '0;
      mret      = 1'b0;
      stall     = 1'b0;
      inst_data = '0;

      // Reset state
      #2;
      exp3("rst", 0, 0, 0);
      push("rst_epc", 3, 0);
      drain();
      tick();
      tick();
      rst_n = 1'b1;

      // 1: sequential fetch and wrap
      inst_data = 16'h0001;
      push("seq1", 0, 1); tick();
      push("seq2", 0, 2); tick();
      push("seq3", 0, 3); tick();
      jump_flag = 1'b1; branch_pc = 16'hFFFF;
      push("jmp_ffff", 0, 16'hFFFF); tick();
      jump_flag = 1'b0;
      push("wrap", 0, 0); tick();
      jump_flag = 1'b1; branch_pc = 16'h0010;
      push("jmp_10", 0, 16'h0010); tick();
      jump_flag = 1'b0;

      // 2: single interrupt, then return
      inst_data = '0;
      irq_en    = 8'hFF;
      irq       = 8'h04;
      exp3("irq2_lat", 16'h0010, 0, 0); tick();
      irq = '0;
      exp3("irq2_take", 16'h0008, 1, 8'h04);
      push("irq2_epc", 3, 16'h0011); tick();
      exp3("irq2_hold", 16'h0008, 1, 0); tick();
      mret = 1'b1;
      exp3("irq2_mret", 16'h0011, 0, 0); tick();
      mret = 1'b0;

      // 3: simultaneous lines, lowest first, second after return
      jump_flag = 1'b1; branch_pc = 16'h0013;
      push("jmp_13", 0, 16'h0013); tick();
      jump_flag = 1'b0;
      irq = 8'h22;
      exp3("dual_lat", 16'h0013, 0, 0); tick();
      irq = '0;
      exp3("dual_take1", 16'h0004, 1, 8'h02);
      push("dual_epc1", 3, 16'h0014); tick();
      exp3("dual_nonest", 16'h0004, 1, 0); tick();
      mret = 1'b1;
      exp3("dual_ret", 16'h0014, 0, 0); tick();
      mret = 1'b0;
      exp3("dual_take5", 16'h0014, 1, 8'h20);
      push("dual_epc5", 3, 16'h0015); tick();
      mret = 1'b1;
      exp3("dual_ret5", 16'h0015, 0, 0); tick();
      mret = 1'b0;

      // 4: take coincident with branch; mret beats branch; mret in RUN ignored
      irq = 8'h01;
      exp3("tj_lat", 16'h0015, 0, 0); tick();
      irq = '0;
      jump_flag = 1'b1; branch_pc = 16'h0040;
      exp3("tj_take", 16'h0000, 1, 8'h01);
      push("tj_epc", 3, 16'h0040); tick();
      branch_pc = 16'h0077;
      mret      = 1'b1;
      exp3("mret_over_jmp", 16'h0040, 0, 0); tick();
      jump_flag = 1'b0;
      inst_data = 16'h0001;
      exp3("mret_in_run", 16'h0041, 0, 0); tick();
      mret      = 1'b0;
      inst_data = '0;

      // 5: disabled line stays latched; stall blocks the take
      irq_en = 8'hF7;
      irq    = 8'h08;
      exp3("dis_lat", 16'h0041, 0, 0); tick();
      irq = '0;
      exp3("dis_none1", 16'h0041, 0, 0); tick();
      exp3("dis_none2", 16'h0041, 0, 0); tick();
      stall     = 1'b1;
      irq_en    = 8'hFF;
      inst_data = 16'h0001;
      exp3("stall1", 16'h0041, 0, 0); tick();
      exp3("stall2", 16'h0041, 0, 0); tick();
      stall     = 1'b0;
      inst_data = '0;
      exp3("en_take", 16'h000C, 1, 8'h08);
      push("en_epc", 3, 16'h0042); tick();

      // 6: reset inside the handler with a pending line
      irq = 8'h10;
      exp3("isr_latch4", 16'h000C, 1, 0); tick();
      irq = '0;
      rst_n = 1'b0;
      #1;
      exp3("arst", 0, 0, 0);
      push("arst_epc", 3, 0);
      drain();
      tick();
      rst_n = 1'b1;
      exp3("post_rst1", 0, 0, 0); tick();
      exp3("post_rst2", 0, 0, 0); tick();
      exp3("post_rst3", 0, 0, 0); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
